// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32x32 register file write port.
// Buffers {addr, data} write-back requests in a circular FIFO and drains at most one per
// cycle into the register file. Optional read-after-write forwarding on both read ports
// is built when the macro WBQ_FORWARD_EN is defined; otherwise the read data passes
// straight through from the register file.
module regfile_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         wr_hold,
  output logic [DATA_W-1:0]            wrData,
  output logic [ADDR_W-1:0]            wrAddr,
  output logic                         write,
  input  logic [ADDR_W-1:0]            rdAddrA,
  input  logic [ADDR_W-1:0]            rdAddrB,
  input  logic [DATA_W-1:0]            rfDataA,
  input  logic [DATA_W-1:0]            rfDataB,
  output logic [DATA_W-1:0]            fwdDataA,
  output logic [DATA_W-1:0]            fwdDataB,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Entry storage; contents are only meaningful while occupied, so no reset.
  logic [ADDR_W-1:0] entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];

  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Status flags come from registered occupancy only.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  // A pop does not free a slot for a push in the same cycle.
  assign push = in_valid && !full;

  // Drain outputs depend only on registered state and wr_hold.
  assign write  = !empty && !wr_hold;
  assign pop    = write;
  assign wrAddr = empty ? '0 : entryAddr[headPtr_q];
  assign wrData = empty ? '0 : entryData[headPtr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    if (push) begin
      tailPtr_d = tailPtr_q + PTR_W'(1);
    end
    if (pop) begin
      headPtr_d = headPtr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset discards every queued entry immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
    end
  end

  // Capture an accepted request into the tail entry.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[tailPtr_q] <= in_addr;
      entryData[tailPtr_q] <= in_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  // Forwarding: walk occupied entries oldest to youngest so the youngest match wins.
  // The head entry is included even while it is being written this cycle.
  always_comb begin
    fwdDataA = rfDataA;
    fwdDataB = rfDataB;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = headPtr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (entryAddr[idx] == rdAddrA) begin
          fwdDataA = entryData[idx];
        end
        if (entryAddr[idx] == rdAddrB) begin
          fwdDataB = entryData[idx];
        end
      end
    end
  end
`else
  // No forwarding: the consumer stalls reads of registers with pending writes.
  logic unusedRdAddr;
  assign unusedRdAddr = ^{rdAddrA, rdAddrB};
  assign fwdDataA     = rfDataA;
  assign fwdDataB     = rfDataB;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios followed by random traffic,
// checked against a queue-plus-register-file reference model.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_hold;
  logic [31:0] wrData;
  logic [4:0]  wrAddr;
  logic        write;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic [31:0] rfDataA;
  logic [31:0] rfDataB;
  logic [31:0] fwdDataA;
  logic [31:0] fwdDataB;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic        full;
  logic        empty;

  regfile_wb_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_hold  (wr_hold),
    .wrData   (wrData),
    .wrAddr   (wrAddr),
    .write    (write),
    .rdAddrA  (rdAddrA),
    .rdAddrB  (rdAddrB),
    .rfDataA  (rfDataA),
    .rfDataB  (rfDataB),
    .fwdDataA (fwdDataA),
    .fwdDataB (fwdDataB),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];        // pending writes, oldest first
  logic [31:0] rf[32];      // register file contents
  logic [31:0] latest[32];  // newest value ever accepted for each register

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fwd(input logic [4:0] a);
`ifdef WBQ_FORWARD_EN
    return latest[a];
`else
    return rf[a];
`endif
  endfunction

  // Drive one cycle of stimulus mid-cycle, then compare every output with the model.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic h, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wr_hold  = h;
    rdAddrA  = ra;
    rdAddrB  = rb;
    rfDataA  = rf[ra];
    rfDataB  = rf[rb];
    #1;
    check_eq("count", 32'(count), q.size());
    check_eq("full", 32'(full), 32'(q.size() == DEPTH));
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check_eq("write", 32'(write), 32'(q.size() != 0 && !h));
    check_eq("wrAddr", 32'(wrAddr), (q.size() != 0) ? 32'(q[0].addr) : 32'h0);
    check_eq("wrData", wrData, (q.size() != 0) ? q[0].data : 32'h0);
    check_eq("fwdDataA", fwdDataA, exp_fwd(ra));
    check_eq("fwdDataB", fwdDataB, exp_fwd(rb));
  endtask

  // Advance the model across the rising edge using the inputs held since drive().
  task automatic commit();
    bit     doPop;
    bit     doPush;
    entry_t e;
    @(posedge clk);
    doPop  = (q.size() != 0) && !wr_hold;
    doPush = in_valid && (q.size() < DEPTH);
    if (doPop) begin
      e = q.pop_front();
      rf[e.addr] = e.data;
    end
    if (doPush) begin
      q.push_back(entry_t'{addr: in_addr, data: in_data});
      latest[in_addr] = in_data;
    end
  endtask

  task automatic idle(input logic h);
    drive(1'b0, 5'd0, 32'h0, h, 5'd3, 5'd4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    wr_hold  = 1'b0;
    rdAddrA  = '0;
    rdAddrB  = '0;
    rfDataA  = '0;
    rfDataB  = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i]     = $urandom;
      latest[i] = rf[i];
    end

    // Reset state
    #3;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_wrAddr", 32'(wrAddr), 32'd0);
    check_eq("rst_wrData", wrData, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // Single push: write appears on the next cycle, queue empties after that
    drive(1'b1, 5'd1, 32'hABCDEFAB, 1'b0, 5'd1, 5'd2);
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
    check_eq("single_write", 32'(write), 32'd1);
    check_eq("single_wrAddr", 32'(wrAddr), 32'd1);
    check_eq("single_wrData", wrData, 32'hABCDEFAB);
    commit();
    idle(1'b0);
    check_eq("single_empty", 32'(empty), 32'd1);
    commit();

    // Fill under hold, drop a fifth request, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(2 + i), $urandom, 1'b1, 5'(2 + i), 5'd7);
      commit();
    end
    drive(1'b1, 5'd30, 32'hBAD0BAD0, 1'b1, 5'd30, 5'd5);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_count", 32'(count), 32'd4);
    commit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'(2 + i), 5'd30);
      check_eq("drain_write", 32'(write), 32'd1);
      check_eq("drain_wrAddr", 32'(wrAddr), 32'(2 + i));
      commit();
    end
    idle(1'b0);
    check_eq("drain_empty", 32'(empty), 32'd1);
    commit();

    // Streaming through the wrap: one in flight, no gaps
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(10 + i), $urandom, 1'b0, 5'(10 + i), 5'(9 + i));
      if (i > 0) begin
        check_eq("stream_count", 32'(count), 32'd1);
        check_eq("stream_write", 32'(write), 32'd1);
        check_eq("stream_wrAddr", 32'(wrAddr), 32'(9 + i));
      end
      commit();
    end
    idle(1'b0);
    check_eq("stream_last", 32'(wrAddr), 32'd19);
    commit();

    // Youngest-match forwarding and the no-match path
    rf[8]     = 32'h0;
    latest[8] = 32'h0;
    rf[1]     = 32'hDEADBEEF;
    latest[1] = 32'hDEADBEEF;
    drive(1'b1, 5'd8, 32'h11111111, 1'b1, 5'd8, 5'd1);
    commit();
    drive(1'b1, 5'd8, 32'h01234567, 1'b1, 5'd8, 5'd1);
    commit();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd1);
`ifdef WBQ_FORWARD_EN
    check_eq("fwd_youngest", fwdDataA, 32'h01234567);
`else
    check_eq("fwd_passthru", fwdDataA, 32'h0);
`endif
    check_eq("fwd_nomatch", fwdDataB, 32'hDEADBEEF);
    commit();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd1);
      commit();
    end

    // Random traffic with a narrow address range to provoke duplicates
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 9) < 7), a, $urandom, ($urandom_range(0, 9) < 3),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      commit();
    end

    // Asynchronous reset while three entries are queued
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(1'b0);
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), $urandom, 1'b1, 5'(20 + i), 5'd0);
      commit();
    end
    wr_hold  = 1'b0;
    in_valid = 1'b0;
    #2;
    check_eq("pre_rst_write", 32'(write), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_write", 32'(write), 32'd0);
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_empty", 32'(empty), 32'd1);
    q.delete();
    for (int i = 0; i < 32; i++) latest[i] = rf[i];
    @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'(20 + i), 5'd21);
      check_eq("postrst_write", 32'(write), 32'd0);
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
